// File: rtl/mem_ctrl.sv
// Byte-wide RAM port owner for the MEM and IF stages.
// MEM accesses pass straight through; IF words come from a 4-byte fetch sequencer that MEM can preempt.
module mem_ctrl #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned IF_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mem_request,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data_i,
  output logic [7:0]        mem_data_o,
  input  logic              if_request,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_inst,
  output logic              if_done,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              ram_wr,
  input  logic [7:0]        ram_din
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    LAST,
    DONE
  } state_t;

  localparam logic [1:0] CNT_LAST = 2'(IF_BYTES - 1);

  state_t     state, state_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic       cap_en;
  logic [1:0] cap_idx;
  logic       mem_active;

  assign mem_active = |mem_request;

  // Each FETCH cycle with cnt>0 captures the byte issued one cycle earlier;
  // LAST captures the final byte issued in the cnt=3 cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cap_en    = 1'b0;
    cap_idx   = cnt - 2'd1;
    case (state)
      IDLE: begin
        if (if_request && !mem_active) begin
          state_nxt = FETCH;
          cnt_nxt   = '0;
        end
      end
      FETCH: begin
        if (mem_active || !if_request) begin
          state_nxt = IDLE;
        end else begin
          cap_en = (cnt != '0);
          if (cnt == CNT_LAST) begin
            state_nxt = LAST;
          end else begin
            cnt_nxt = cnt + 2'd1;
          end
        end
      end
      LAST: begin
        if (mem_active || !if_request) begin
          state_nxt = IDLE;
        end else begin
          cap_en    = 1'b1;
          cap_idx   = CNT_LAST;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      if_inst <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (cap_en) begin
        if_inst[{cap_idx, 3'b000} +: 8] <= ram_din;
      end
    end
  end

  always_comb begin
    ram_a    = '0;
    ram_wr   = 1'b0;
    ram_dout = '0;
    if (!rst) begin
      if (mem_active) begin
        ram_a    = mem_addr;
        ram_wr   = (mem_request == 2'b10);
        ram_dout = mem_data_i;
      end else if (state == FETCH) begin
        ram_a = if_addr + ADDR_W'(cnt);
      end
    end
  end

  assign mem_data_o = rst ? '0 : ram_din;
  assign if_done    = (state == DONE);

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a behavioural 1-cycle-latency byte RAM.
module tb_mem_ctrl;

  logic        clk;
  logic        rst;
  logic [1:0]  mem_request;
  logic [31:0] mem_addr;
  logic [7:0]  mem_data_i;
  logic [7:0]  mem_data_o;
  logic        if_request;
  logic [31:0] if_addr;
  logic [31:0] if_inst;
  logic        if_done;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [7:0]  ram_din;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [7:0] ram [0:65535];

  logic [31:0] st_addr [13] = '{32'h1000, 32'h1001, 32'h1002, 32'h1003,
                                32'h1004, 32'h1005, 32'h1006, 32'h1007,
                                32'h2000, 32'h2001, 32'h2002, 32'h2003, 32'h2001};
  logic [7:0]  st_data [13] = '{8'h13, 8'h05, 8'h10, 8'h00,
                                8'h93, 8'h08, 8'h20, 8'h00,
                                8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h80};
  logic [7:0]  ld_exp  [4]  = '{8'hAA, 8'h80, 8'hCC, 8'hDD};

  mem_ctrl #(.ADDR_W(32), .IF_BYTES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_request (mem_request),
    .mem_addr    (mem_addr),
    .mem_data_i  (mem_data_i),
    .mem_data_o  (mem_data_o),
    .if_request  (if_request),
    .if_addr     (if_addr),
    .if_inst     (if_inst),
    .if_done     (if_done),
    .ram_a       (ram_a),
    .ram_dout    (ram_dout),
    .ram_wr      (ram_wr),
    .ram_din     (ram_din)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr) ram[ram_a[15:0]] <= ram_dout;
    ram_din <= ram[ram_a[15:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Call in the IDLE cycle where the request is first seen; returns in the DONE cycle.
  task automatic fetch_seq(input logic [31:0] addr, input logic [31:0] word);
    for (int unsigned i = 0; i < 4; i++) begin
      cyc(); #1;
      check("fetch_ram_a", ram_a, addr + i);
      check("fetch_ram_wr", ram_wr, 1'b0);
      check("fetch_busy_done", if_done, 1'b0);
    end
    cyc(); #1;
    check("last_done", if_done, 1'b0);
    check("last_ram_a", ram_a, 32'h0);
    cyc(); #1;
    check("done_pulse", if_done, 1'b1);
    check("done_inst", if_inst, word);
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    mem_request = 2'b10;
    mem_addr = 32'h1234;
    mem_data_i = 8'h5A;
    if_request = 1'b1;
    if_addr = 32'h1000;
    cyc(); cyc(); #1;
    check("rst_ram_a", ram_a, 32'h0);
    check("rst_ram_wr", ram_wr, 1'b0);
    check("rst_ram_dout", ram_dout, 8'h00);
    check("rst_mem_data_o", mem_data_o, 8'h00);
    check("rst_if_done", if_done, 1'b0);
    check("rst_if_inst", if_inst, 32'h0);

    cyc();
    rst = 1'b0; mem_request = 2'b00; if_request = 1'b0; #1;
    check("idle_ram_a", ram_a, 32'h0);
    check("idle_ram_wr", ram_wr, 1'b0);

    // MEM stores pass straight through
    for (int unsigned i = 0; i < 13; i++) begin
      cyc();
      mem_request = 2'b10; mem_addr = st_addr[i]; mem_data_i = st_data[i]; #1;
      check("st_ram_wr", ram_wr, 1'b1);
      check("st_ram_a", ram_a, st_addr[i]);
      check("st_ram_dout", ram_dout, st_data[i]);
      check("st_if_done", if_done, 1'b0);
    end

    // MEM loads, last one with the reserved encoding
    for (int unsigned i = 0; i < 4; i++) begin
      cyc();
      mem_request = (i == 3) ? 2'b11 : 2'b01; mem_addr = 32'h2000 + i; #1;
      check("ld_ram_a", ram_a, 32'h2000 + i);
      check("ld_ram_wr", ram_wr, 1'b0);
      if (i > 0) check("ld_data", mem_data_o, ld_exp[i-1]);
    end
    cyc();
    mem_request = 2'b00; #1;
    check("ld_data_last", mem_data_o, ld_exp[3]);
    check("ld_idle_ram_a", ram_a, 32'h0);

    // basic fetch
    cyc();
    if_request = 1'b1; if_addr = 32'h1000; #1;
    check("f1_req_ram_a", ram_a, 32'h0);
    check("f1_req_done", if_done, 1'b0);
    fetch_seq(32'h1000, 32'h00100513);
    if_request = 1'b0;
    cyc(); #1;
    check("f1_after_done", if_done, 1'b0);

    // held request: second pulse at c+13, none at c+7
    cyc();
    if_request = 1'b1; if_addr = 32'h1004; #1;
    fetch_seq(32'h1004, 32'h00200893);
    cyc(); #1;
    check("f6_c7_done", if_done, 1'b0);
    check("f6_c7_ram_a", ram_a, 32'h0);
    fetch_seq(32'h1004, 32'h00200893);
    if_request = 1'b0;
    cyc(); #1;
    check("f6_after_done", if_done, 1'b0);

    // preemption at cnt=2 by a 4-byte MEM load
    cyc();
    if_request = 1'b1; if_addr = 32'h1000; #1;
    cyc(); #1;
    check("pre_cnt0", ram_a, 32'h1000);
    cyc(); #1;
    check("pre_cnt1", ram_a, 32'h1001);
    for (int unsigned j = 0; j < 4; j++) begin
      cyc();
      mem_request = 2'b01; mem_addr = 32'h2000 + j; #1;
      check("pre_ram_a", ram_a, 32'h2000 + j);
      check("pre_ram_wr", ram_wr, 1'b0);
      check("pre_done", if_done, 1'b0);
      if (j > 0) check("pre_ld_data", mem_data_o, ld_exp[j-1]);
    end
    cyc();
    mem_request = 2'b00; #1;
    check("pre_ld_last", mem_data_o, ld_exp[3]);
    check("pre_restart_ram_a", ram_a, 32'h0);
    check("pre_restart_done", if_done, 1'b0);
    fetch_seq(32'h1000, 32'h00100513);
    if_request = 1'b0;
    cyc(); #1;
    check("pre_after_done", if_done, 1'b0);

    // abort at cnt=1
    cyc();
    if_request = 1'b1; if_addr = 32'h1004; #1;
    cyc(); #1;
    check("ab_cnt0", ram_a, 32'h1004);
    cyc();
    if_request = 1'b0; #1;
    check("ab_cnt1", ram_a, 32'h1005);
    for (int unsigned i = 0; i < 6; i++) begin
      cyc(); #1;
      check("ab_done", if_done, 1'b0);
      check("ab_ram_a", ram_a, 32'h0);
    end

    // reset while in LAST
    cyc();
    if_request = 1'b1; if_addr = 32'h1000; #1;
    for (int unsigned i = 0; i < 4; i++) cyc();
    cyc(); #1;
    check("rl_last_done", if_done, 1'b0);
    check("rl_last_inst", if_inst, 32'h00100513);
    rst = 1'b1;
    cyc();
    rst = 1'b0; if_request = 1'b0; #1;
    check("rl_if_inst", if_inst, 32'h0);
    check("rl_if_done", if_done, 1'b0);
    check("rl_ram_a", ram_a, 32'h0);
    check("rl_ram_wr", ram_wr, 1'b0);
    cyc(); #1;
    check("rl_no_done", if_done, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
